// File: rtl/serial_seq_detector_if.sv
// Purpose : Bundles the serial bit stream and the detector results.
//   din          serial data bit (registered dff q from upstream)
//   din_valid    din is consumed only when high
//   match        one-cycle pulse per detected pattern
//   match_count  saturating match count since clear
//   count_sat    sticky, high once match_count is all-ones
// Modports: master = stream source / result consumer, slave = detector.
interface serial_seq_detector_if #(
  parameter int CNT_W = 8
);
  logic             din;
  logic             din_valid;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (output din, din_valid, input match, match_count, count_sat);
  modport slave  (input din, din_valid, output match, match_count, count_sat);
endinterface

// File: rtl/serial_seq_detector.sv
// Purpose : Serial pattern detector. Shifts in one accepted bit per qualified
//           clock and pulses match (1 clk latency) when the last PAT_W accepted
//           bits equal PATTERN (MSB = oldest bit).
// Ports   : clk   rising-edge clock
//           clear synchronous active-high reset, highest priority
//           bus   serial_seq_detector_if.slave (din, din_valid, match,
//                 match_count, count_sat)
// Config  : SEQ_DET_COUNT_EN defined   -> saturating match counter + sticky
//                                         count_sat are built.
//           SEQ_DET_COUNT_EN undefined -> match_count and count_sat tied to 0.
module serial_seq_detector #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 clear,
  serial_seq_detector_if.slave bus
);
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] ARM_LVL  = FILL_W'(PAT_W - 1);

  // ARMED means one more accepted bit can complete the pattern.
  typedef enum logic {FILLING, ARMED} state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               match_q, match_d;
  logic [PAT_W-1:0]   nxt;
  logic               hit;

  always_comb begin
    nxt     = {hist_q[PAT_W-2:0], bus.din};
    // The ARMED gate keeps the zeroed history after clear from aliasing a
    // pattern that contains leading zeros.
    hit     = bus.din_valid && (state_q == ARMED) && (nxt == PATTERN);
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = hit;
    if (bus.din_valid) begin
      hist_d = nxt;
      fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
      if (hit && !OVERLAP) begin
        hist_d = '0;
        fill_d = '0;
      end
    end
    state_d = (fill_d >= ARM_LVL) ? ARMED : FILLING;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= FILLING;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign bus.match = match_q;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // Counter stops at all-ones; count_sat latches on the edge it gets there.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == {CNT_W{1'b1}}) sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign bus.match_count = cnt_q;
  assign bus.count_sat   = sat_q;
`else
  assign bus.match_count = {CNT_W{1'b0}};
  assign bus.count_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_seq_detector.sv
// Directed bench: three detectors on one shared stream.
//   dut_ov : PATTERN 1011, OVERLAP=1, CNT_W=8
//   dut_no : PATTERN 1011, OVERLAP=0, CNT_W=8
//   dut_c2 : PATTERN 1011, OVERLAP=1, CNT_W=2 (saturation)
// Inputs change on negedge; outputs are sampled on the following negedge.
module tb_serial_seq_detector;
`ifdef SEQ_DET_COUNT_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif

  logic clk = 1'b0;
  logic clear, din, din_valid;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  serial_seq_detector_if #(.CNT_W(8)) if_ov ();
  serial_seq_detector_if #(.CNT_W(8)) if_no ();
  serial_seq_detector_if #(.CNT_W(2)) if_c2 ();

  assign if_ov.din = din;  assign if_ov.din_valid = din_valid;
  assign if_no.din = din;  assign if_no.din_valid = din_valid;
  assign if_c2.din = din;  assign if_c2.din_valid = din_valid;

  serial_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8))
    dut_ov (.clk(clk), .clear(clear), .bus(if_ov));
  serial_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8))
    dut_no (.clk(clk), .clear(clear), .bus(if_no));
  serial_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2))
    dut_c2 (.clk(clk), .clear(clear), .bus(if_c2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive one cycle, then check match on all three instances.
  task automatic feed(input logic c, input logic b, input logic v,
                      input logic e_ov, input logic e_no, input string tag);
    clear = c; din = b; din_valid = v;
    @(negedge clk);
    chk({tag, "/ov.match"}, 32'(if_ov.match), 32'(e_ov));
    chk({tag, "/no.match"}, 32'(if_no.match), 32'(e_no));
    chk({tag, "/c2.match"}, 32'(if_c2.match), 32'(e_ov));
  endtask

  task automatic chk_cnt(input string tag, input int ov, input int no,
                         input int c2, input int c2sat);
    chk({tag, "/ov.cnt"}, 32'(if_ov.match_count), 32'(ov * CE));
    chk({tag, "/no.cnt"}, 32'(if_no.match_count), 32'(no * CE));
    chk({tag, "/c2.cnt"}, 32'(if_c2.match_count), 32'(c2 * CE));
    chk({tag, "/c2.sat"}, 32'(if_c2.count_sat),   32'(c2sat * CE));
    chk({tag, "/ov.sat"}, 32'(if_ov.count_sat),   32'd0);
  endtask

  initial begin
    logic [6:0]  s2;
    logic [6:0]  m2ov, m2no;
    logic [15:0] s6, m6ov, m6no;
    int          k;
    int          cnt_tab [5] = '{1, 2, 3, 3, 3};
    int          sat_tab [5] = '{0, 0, 1, 1, 1};

    clear = 1'b1; din = 1'b0; din_valid = 1'b0;

    // 1: clear held with random stream
    for (int i = 0; i < 2; i++)
      feed(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, "rst");
    chk_cnt("rst", 0, 0, 0, 0);

    // 2/3: stream 1,0,1,1,0,1,1 (index 6 = first bit)
    s2   = 7'b1011011;
    m2ov = 7'b0001001;
    m2no = 7'b0001000;
    for (int i = 6; i >= 0; i--)
      feed(1'b0, s2[i], 1'b1, m2ov[i], m2no[i], "t2");
    chk_cnt("t2", 2, 1, 2, 0);

    // 4: 1,0, gap of 5 with din=1, then 1,1
    feed(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t4clr");
    chk_cnt("t4clr", 0, 0, 0, 0);
    feed(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t4");
    feed(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t4");
    for (int i = 0; i < 5; i++)
      feed(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t4gap");
    feed(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t4");
    feed(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "t4hit");
    feed(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t4idle");
    chk_cnt("t4", 1, 1, 1, 0);

    // 5: 1,0,1, clear (with a valid 1 present), 1 -> no match; 0,1,1 -> match
    feed(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t5clr");
    feed(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t5");
    feed(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t5");
    feed(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t5");
    feed(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "t5midclr");
    feed(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t5stale");
    feed(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t5");
    feed(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t5");
    feed(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "t5hit");
    chk_cnt("t5", 1, 1, 1, 0);

    // 6: five overlapping matches, counter saturation on the 2-bit instance
    feed(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6clr");
    s6   = 16'b1011011011011011;
    m6ov = 16'b0001001001001001;
    m6no = 16'b0001000001000001;
    k = 0;
    for (int i = 15; i >= 0; i--) begin
      feed(1'b0, s6[i], 1'b1, m6ov[i], m6no[i], "t6");
      if (m6ov[i]) begin
        chk("t6/c2.cnt", 32'(if_c2.match_count), 32'(cnt_tab[k] * CE));
        chk("t6/c2.sat", 32'(if_c2.count_sat),   32'(sat_tab[k] * CE));
        k++;
      end
    end
    chk_cnt("t6", 5, 3, 3, 1);

    // clear releases the sticky flag and the counters
    feed(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "endclr");
    chk_cnt("endclr", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
